clock_manager_sequencer: RTL

//  Power-up/recovery sequencer for the 48 MHz clock manager (clockdcm). Runs on the

---
 rtl/clock_manager_sequencer_if.sv | 25 ++
 rtl/clock_manager_sequencer.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/clock_manager_sequencer_if.sv
// Handshake bundle between the clock-manager sequencer and its environment.
// The master drives the PLL lock status and divider programming; the slave
// (the sequencer) returns the PLL/system resets, sample strobe and status.
interface clock_manager_sequencer_if #(
   parameter int DIV_W = 8
);
   logic             pll_locked;
   logic             div_load;
   logic [DIV_W-1:0] div_value;
   logic             pll_resetb;
   logic             sys_rst_n;
   logic             sample_en;
   logic [1:0]       state;
   logic [7:0]       retry_cnt;

   modport master (
      output pll_locked, div_load, div_value,
      input  pll_resetb, sys_rst_n, sample_en, state, retry_cnt
   );

   modport slave (
      input  pll_locked, div_load, div_value,
      output pll_resetb, sys_rst_n, sample_en, state, retry_cnt
   );
endinterface

// File: rtl/clock_manager_sequencer.sv
// Power-up / recovery sequencer for the 48 MHz clock manager. Pulses the PLL
// reset, waits for a synchronised lock with timeout and retry, qualifies lock
// stability, then releases the downstream reset and generates the ADC sample
// strobe from a programmable divider. Any lock loss in RUN re-sequences.
module clock_manager_sequencer #(
   parameter int PLL_RST_CYC  = 16,
   parameter int LOCK_TIMEOUT = 4096,
   parameter int STABLE_CYC   = 256,
   parameter int DIV_W        = 8,
   parameter int DIV_DEFAULT  = 11
) (
   input logic                      clk,
   input logic                      reset,
   clock_manager_sequencer_if.slave bus
);

   typedef enum logic [1:0] {
      ST_PLL_RST   = 2'd0,
      ST_WAIT_LOCK = 2'd1,
      ST_STABLE    = 2'd2,
      ST_RUN       = 2'd3
   } state_t;

   // One shared counter serves all timed states, so size it for the longest.
   localparam int CNT_MAX_A = (PLL_RST_CYC > LOCK_TIMEOUT) ? PLL_RST_CYC : LOCK_TIMEOUT;
   localparam int CNT_MAX   = (CNT_MAX_A > STABLE_CYC) ? CNT_MAX_A : STABLE_CYC;
   localparam int CNT_W     = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(PLL_RST_CYC - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYC - 1);
   localparam logic [DIV_W-1:0] DIV_RST     = DIV_W'(DIV_DEFAULT);

   logic             sync1_r;
   logic             lk_r;
   state_t           state_r;
   state_t           state_nxt_s;
   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cnt_nxt_s;
   logic             retry_inc_s;
   logic [7:0]       retry_r;
   logic [DIV_W-1:0] div_cur_r;
   logic [DIV_W-1:0] div_cur_nxt_s;
   logic [DIV_W-1:0] div_pend_r;
   logic [DIV_W-1:0] div_pend_nxt_s;
   logic [DIV_W-1:0] phase_r;
   logic [DIV_W-1:0] phase_nxt_s;
   logic             stay_run_s;
   logic             sample_nxt_s;
   logic             pll_resetb_r;
   logic             sys_rst_n_r;
   logic             sample_en_r;

   // Two-flop synchroniser bringing the asynchronous PLL lock into clk.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_r <= 1'b0;
         lk_r    <= 1'b0;
      end else begin
         sync1_r <= bus.pll_locked;
         lk_r    <= sync1_r;
      end
   end

   // Sequencing decisions: next state, shared cycle counter, retry event.
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      retry_inc_s = 1'b0;
      case (state_r)
         ST_PLL_RST: begin
            if (cnt_r == RST_LAST) begin
               state_nxt_s = ST_WAIT_LOCK;
               cnt_nxt_s   = {CNT_W{1'b0}};
            end else begin
               cnt_nxt_s = cnt_r + CNT_W'(1);
            end
         end
         ST_WAIT_LOCK: begin
            // Lock is checked before the timeout so a lock on the last cycle wins.
            if (lk_r) begin
               state_nxt_s = ST_STABLE;
               cnt_nxt_s   = {CNT_W{1'b0}};
            end else if (cnt_r == TIMEOUT_LAST) begin
               state_nxt_s = ST_PLL_RST;
               cnt_nxt_s   = {CNT_W{1'b0}};
               retry_inc_s = 1'b1;
            end else begin
               cnt_nxt_s = cnt_r + CNT_W'(1);
            end
         end
         ST_STABLE: begin
            if (!lk_r) begin
               state_nxt_s = ST_WAIT_LOCK;
               cnt_nxt_s   = {CNT_W{1'b0}};
            end else if (cnt_r == STABLE_LAST) begin
               state_nxt_s = ST_RUN;
               cnt_nxt_s   = {CNT_W{1'b0}};
            end else begin
               cnt_nxt_s = cnt_r + CNT_W'(1);
            end
         end
         ST_RUN: begin
            if (!lk_r) begin
               state_nxt_s = ST_PLL_RST;
               retry_inc_s = 1'b1;
            end else begin
               state_nxt_s = ST_RUN;
            end
            cnt_nxt_s = {CNT_W{1'b0}};
         end
         default: begin
            state_nxt_s = ST_PLL_RST;
            cnt_nxt_s   = {CNT_W{1'b0}};
         end
      endcase
   end

   // Sample divider: phase runs only while staying in RUN; new divisor is
   // adopted at a wrap, or at once outside RUN, never mid-period.
   always_comb begin
      div_pend_nxt_s = bus.div_load ? bus.div_value : div_pend_r;
      stay_run_s     = (state_r == ST_RUN) && (state_nxt_s == ST_RUN);
      div_cur_nxt_s  = div_cur_r;
      phase_nxt_s    = phase_r;
      sample_nxt_s   = 1'b0;
      if (!stay_run_s) begin
         div_cur_nxt_s = div_pend_nxt_s;
         phase_nxt_s   = {DIV_W{1'b0}};
      end else if (phase_r == div_cur_r) begin
         div_cur_nxt_s = div_pend_nxt_s;
         phase_nxt_s   = {DIV_W{1'b0}};
         sample_nxt_s  = 1'b1;
      end else begin
         phase_nxt_s = phase_r + DIV_W'(1);
      end
   end

   // State, counters, divider and registered outputs (derived from next state
   // so every output lines up with the state it belongs to).
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r      <= ST_PLL_RST;
         cnt_r        <= {CNT_W{1'b0}};
         retry_r      <= 8'd0;
         div_cur_r    <= DIV_RST;
         div_pend_r   <= DIV_RST;
         phase_r      <= {DIV_W{1'b0}};
         pll_resetb_r <= 1'b0;
         sys_rst_n_r  <= 1'b0;
         sample_en_r  <= 1'b0;
      end else begin
         state_r      <= state_nxt_s;
         cnt_r        <= cnt_nxt_s;
         div_cur_r    <= div_cur_nxt_s;
         div_pend_r   <= div_pend_nxt_s;
         phase_r      <= phase_nxt_s;
         pll_resetb_r <= (state_nxt_s != ST_PLL_RST);
         sys_rst_n_r  <= (state_nxt_s == ST_RUN);
         sample_en_r  <= sample_nxt_s;
         if (retry_inc_s && (retry_r != 8'hFF)) begin
            retry_r <= retry_r + 8'd1;
         end else begin
            retry_r <= retry_r;
         end
      end
   end

   assign bus.pll_resetb = pll_resetb_r;
   assign bus.sys_rst_n  = sys_rst_n_r;
   assign bus.sample_en  = sample_en_r;
   assign bus.state      = state_r;
   assign bus.retry_cnt  = retry_r;

endmodule
